ppm_frame_sequencer: RTL and testbench
======================================

PPM_FRAME_SEQUENCER -- requirements
Module: ppm_frame_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 6, meaning the number of channel slots per frame (range 1..8).
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of every clock-count field and internal counter.
REQ-003 SHALL have port ACLK, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port ARESET, input, 1, the reset; it is synchronous and active-high.
REQ-005 SHALL have port enable, input, 1, which runs frames while high.
REQ-006 SHALL have port ch_width, input, NUM_CH*CNT_W, giving the high time of each channel in clocks; channel k occupies bits [k*CNT_W +: CNT_W].
REQ-007 SHALL have port gap_width, input, CNT_W, giving the low separator time in clocks.
REQ-008 SHALL have port frame_len, input, CNT_W, giving the total frame period in clocks.
REQ-009 SHALL have port ppm_out, output, 1, the PPM waveform; it idles high.
REQ-010 SHALL have port frame_start, output, 1, a one-cycle pulse at the first cycle of each frame.
REQ-011 SHALL have port busy, output, 1, which is high whenever the state is not IDLE.
REQ-012 SHALL have port cur_ch, output, 3, the index of the active channel; it reads 0 outside GAP and CHAN.
REQ-013 SHALL have port overrun, output, 1, a sticky flag for frame overrun.

Function
REQ-014 SHALL use states IDLE, GAP, CHAN, TGAP and SYNC.
REQ-015 SHALL drive ppm_out as follows: 0 in GAP and TGAP; 1 in CHAN, SYNC and IDLE.
REQ-016 SHALL latch ch_width, gap_width and frame_len into shadow registers on the IDLE->GAP and SYNC->GAP transitions only, so mid-frame input changes take effect at the next frame.
REQ-017 SHALL treat any zero shadow value of ch_width or gap_width as 1 clock.
REQ-018 SHALL go IDLE->GAP on the cycle after enable is sampled high, with frame_start=1, cur_ch=0 and the frame counter cleared, all in that first GAP cycle.
REQ-019 SHALL stay in GAP for exactly gap_width cycles, then go to CHAN with the same cur_ch.
REQ-020 SHALL stay in CHAN for exactly ch_width[cur_ch] cycles, then go to GAP with cur_ch+1, or to TGAP if cur_ch==NUM_CH-1.
REQ-021 SHALL stay in TGAP for gap_width cycles, then go to SYNC.
REQ-022 SHALL stay in SYNC until the frame counter equals frame_len-1.
REQ-023 SHALL count the frame counter once per cycle from 0 at the first GAP cycle, saturating at the all-ones value.
REQ-024 SHALL leave SYNC for GAP (a new frame) if enable is high at the end of SYNC, or for IDLE otherwise.
REQ-025 SHALL finish the current frame when enable falls mid-frame; no truncation.
REQ-026 SHALL, when the frame counter is already >= frame_len-1 on entry to SYNC, hold SYNC for exactly 1 cycle and set overrun.
REQ-027 SHALL clear overrun only by reset.
REQ-028 SHALL run per-state duration counters compared against shadow values; no arithmetic wider than CNT_W.
REQ-029 SHALL register all outputs; no combinational input-to-output path.

Reset
REQ-030 SHALL, while ARESET=1 at a clock edge, force the state to IDLE with ppm_out=1, frame_start=0, busy=0, cur_ch=0, overrun=0, and all counters and shadows 0.
REQ-031 SHALL abandon any frame in progress when reset is asserted mid-frame; after reset release the next frame begins fresh per REQ-018.

Structure
REQ-032 SHALL place the state enum type and the default constants (NUM_CH, CNT_W, default gap 40000 and frame 2000000 clocks for 100 MHz) in package ppm_pkg.
REQ-033 SHALL use one sub-module, ppm_dur_counter: a load/decrement/done down-counter instanced once and reused across states.
REQ-034 SHALL be instantiated by the PPM AXI-lite wrapper, which feeds ch_width, gap_width and frame_len from slave registers and enable from a control bit.

Verification
REQ-035 SHALL cover: NUM_CH=4, gap=2, widths 3,4,5,6, frame=40, enable held high -> ppm_out low 2/high 3/low 2/high 4/low 2/high 5/low 2/high 6/low 2/high 12 cycles; frame_start again at cycle 40.
REQ-036 SHALL cover: same config with frame=20 -> SYNC lasts 1 cycle, the next frame starts at cycle 29, overrun=1 and stays 1.
REQ-037 SHALL cover: ch_width[1] changed from 4 to 9 at cycle 10 of a frame -> the current frame still uses 4 and the next frame's channel-1 high time is 9.
REQ-038 SHALL cover: enable dropped at cycle 5 -> the frame completes at cycle 40, then IDLE with ppm_out=1, busy=0 and no further frame_start.
REQ-039 SHALL cover: ARESET pulsed at cycle 15 -> the next cycle shows IDLE with all outputs at reset values; with enable high, frame_start occurs one cycle after ARESET falls.
REQ-040 SHALL cover: ch_width[2]=0 and gap=0 -> each treated as 1 cycle, with the waveform checked cycle-by-cycle.

Source files
------------

// File: rtl/ppm_pkg.sv
// Shared types and default timing constants for the PPM frame sequencer.
// Defaults assume a 100 MHz core clock (0.4 ms separator, 20 ms frame).
package ppm_pkg;

    localparam int PPM_NUM_CH        = 6;
    localparam int PPM_CNT_W         = 32;
    localparam int PPM_GAP_DEFAULT   = 40000;
    localparam int PPM_FRAME_DEFAULT = 2000000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_CHAN,
        ST_TGAP,
        ST_SYNC
    } ppm_state_e;

endpackage

// File: rtl/ppm_dur_counter.sv
// Load/decrement down-counter timing one FSM state; done is high on the last cycle.
// Load value takes effect on the next cycle; no backpressure, decrements while dec is high.
module ppm_dur_counter #(
    parameter int CNT_W = 32
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // A loaded value of N keeps the state for exactly N cycles.
    assign done = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/ppm_frame_sequencer.sv
// Generates a PPM frame (gap/channel pulses, trailing gap, sync fill to frame_len); outputs registered.
// Inputs are shadowed at frame start; enable is only honoured between frames, never truncating one.
module ppm_frame_sequencer
    import ppm_pkg::*;
#(
    parameter int NUM_CH = PPM_NUM_CH,
    parameter int CNT_W  = PPM_CNT_W
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    enable,
    input  logic [NUM_CH*CNT_W-1:0] ch_width,
    input  logic [CNT_W-1:0]        gap_width,
    input  logic [CNT_W-1:0]        frame_len,
    output logic                    ppm_out,
    output logic                    frame_start,
    output logic                    busy,
    output logic [2:0]              cur_ch,
    output logic                    overrun
);

    localparam logic [2:0]       LAST_CH = 3'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    ppm_state_e       state_q;
    ppm_state_e       state_d;
    logic [2:0]       ch_idx_q;
    logic [2:0]       ch_idx_d;
    logic [CNT_W-1:0] frame_cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] len_last;
    logic [CNT_W-1:0] ch_sh [NUM_CH];
    logic [CNT_W-1:0] gap_sh;
    logic [CNT_W-1:0] len_sh;
    logic [CNT_W-1:0] ch_sel;
    logic [CNT_W-1:0] dur_val;
    logic             start_frame;
    logic             dur_load;
    logic             dur_dec;
    logic             dur_done;
    logic             sync_done;
    logic             ovr_set;

    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    always_comb begin
        ch_sel = ch_sh[0];
        for (int k = 1; k < NUM_CH; k++) begin
            if (ch_idx_q == 3'(k)) begin
                ch_sel = ch_sh[k];
            end
        end
    end

    assign cnt_inc   = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + ONE;
    assign len_last  = len_sh - ONE;
    assign sync_done = (frame_cnt_q >= len_last);
    assign dur_dec   = (state_q != ST_IDLE);

    // Overrun is judged on the counter value SYNC will open with, so the flag shows during SYNC.
    assign ovr_set = (state_q == ST_TGAP) && dur_done && (cnt_inc >= len_last);

    always_comb begin
        state_d     = state_q;
        ch_idx_d    = ch_idx_q;
        start_frame = 1'b0;
        dur_load    = 1'b0;
        dur_val     = gap_sh;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d     = ST_GAP;
                    ch_idx_d    = '0;
                    start_frame = 1'b1;
                    dur_load    = 1'b1;
                    dur_val     = at_least_one(gap_width);
                end
            end
            ST_GAP: begin
                if (dur_done) begin
                    state_d  = ST_CHAN;
                    dur_load = 1'b1;
                    dur_val  = ch_sel;
                end
            end
            ST_CHAN: begin
                if (dur_done) begin
                    dur_load = 1'b1;
                    dur_val  = gap_sh;
                    if (ch_idx_q == LAST_CH) begin
                        state_d = ST_TGAP;
                    end else begin
                        state_d  = ST_GAP;
                        ch_idx_d = ch_idx_q + 3'd1;
                    end
                end
            end
            ST_TGAP: begin
                if (dur_done) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (sync_done) begin
                    if (enable) begin
                        state_d     = ST_GAP;
                        ch_idx_d    = '0;
                        start_frame = 1'b1;
                        dur_load    = 1'b1;
                        dur_val     = at_least_one(gap_width);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    ppm_dur_counter #(
        .CNT_W(CNT_W)
    ) u_dur (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .load    (dur_load),
        .dec     (dur_dec),
        .load_val(dur_val),
        .done    (dur_done)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= ST_IDLE;
            ch_idx_q    <= '0;
            frame_cnt_q <= '0;
            gap_sh      <= '0;
            len_sh      <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                ch_sh[k] <= '0;
            end
            ppm_out     <= 1'b1;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            cur_ch      <= '0;
            overrun     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_idx_q <= ch_idx_d;
            if (start_frame) begin
                frame_cnt_q <= '0;
                gap_sh      <= at_least_one(gap_width);
                len_sh      <= frame_len;
                for (int k = 0; k < NUM_CH; k++) begin
                    ch_sh[k] <= at_least_one(ch_width[k*CNT_W +: CNT_W]);
                end
            end else if (state_q != ST_IDLE) begin
                frame_cnt_q <= cnt_inc;
            end
            // Outputs follow the next state so they line up with the state they describe.
            ppm_out     <= !((state_d == ST_GAP) || (state_d == ST_TGAP));
            frame_start <= start_frame;
            busy        <= (state_d != ST_IDLE);
            cur_ch      <= ((state_d == ST_GAP) || (state_d == ST_CHAN)) ? ch_idx_d : 3'd0;
            if (ovr_set) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ppm_frame_sequencer.sv
// Directed bench: a frame-level model predicts every output cycle, plus literal run-length checks.
module tb_ppm_frame_sequencer;

    localparam int NCH = 4;
    localparam int CW  = 32;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic              enable = 1'b0;
    logic [NCH*CW-1:0] ch_width = '0;
    logic [CW-1:0]     gap_width = '0;
    logic [CW-1:0]     frame_len = '0;
    logic              ppm_out;
    logic              frame_start;
    logic              busy;
    logic [2:0]        cur_ch;
    logic              overrun;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit chk_en      = 1'b0;
    int runs[$];

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc++;

    ppm_frame_sequencer #(
        .NUM_CH(NCH),
        .CNT_W (CW)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .enable     (enable),
        .ch_width   (ch_width),
        .gap_width  (gap_width),
        .frame_len  (frame_len),
        .ppm_out    (ppm_out),
        .frame_start(frame_start),
        .busy       (busy),
        .cur_ch     (cur_ch),
        .overrun    (overrun)
    );

    // Model: one queue entry per cycle of a frame, built from the frame's rules at its start.
    typedef struct packed {
        logic       ppm;
        logic [2:0] ch;
        logic       fs;
        logic       ovr;
    } exp_t;

    exp_t       q[$];
    exp_t       e_cur;
    logic       e_ppm  = 1'b1;
    logic       e_fs   = 1'b0;
    logic       e_busy = 1'b0;
    logic       e_ovr  = 1'b0;
    logic [2:0] e_ch   = 3'd0;

    function automatic void push_n(input int n, input logic p, input int ch);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.ppm = p;
            e.ch  = 3'(ch);
            e.fs  = (q.size() == 0);
            e.ovr = 1'b0;
            q.push_back(e);
        end
    endfunction

    function automatic void build_frame();
        int g;
        int w;
        int t;
        int flen;
        exp_t e;
        g = (gap_width == 0) ? 1 : int'(gap_width);
        for (int k = 0; k < NCH; k++) begin
            w = int'(ch_width[k*CW +: CW]);
            if (w == 0) w = 1;
            push_n(g, 1'b0, k);
            push_n(w, 1'b1, k);
        end
        push_n(g, 1'b0, 0);
        t    = q.size();
        flen = int'(frame_len);
        if (t >= flen - 1) begin
            e = '{ppm: 1'b1, ch: 3'd0, fs: 1'b0, ovr: 1'b1};
            q.push_back(e);
        end else begin
            push_n(flen - t, 1'b1, 0);
        end
    endfunction

    always @(posedge ACLK) begin
        if (ARESET) begin
            q.delete();
            e_ppm = 1'b1; e_fs = 1'b0; e_busy = 1'b0; e_ch = 3'd0; e_ovr = 1'b0;
        end else begin
            if (q.size() == 0 && enable) build_frame();
            if (q.size() > 0) begin
                e_cur  = q.pop_front();
                e_ppm  = e_cur.ppm;
                e_ch   = e_cur.ch;
                e_fs   = e_cur.fs;
                e_busy = 1'b1;
                e_ovr  = e_ovr | e_cur.ovr;
            end else begin
                e_ppm = 1'b1; e_fs = 1'b0; e_busy = 1'b0; e_ch = 3'd0;
            end
        end
    end

    always @(negedge ACLK) begin
        if (chk_en) begin
            vectors++;
            if (ppm_out !== e_ppm || frame_start !== e_fs || busy !== e_busy ||
                cur_ch !== e_ch || overrun !== e_ovr) begin
                miscompares++;
                $display("FAIL cycle %0d outputs: got ppm=%b fs=%b busy=%b ch=%0d ovr=%b, expected ppm=%b fs=%b busy=%b ch=%0d ovr=%b",
                         cyc, ppm_out, frame_start, busy, cur_ch, overrun,
                         e_ppm, e_fs, e_busy, e_ch, e_ovr);
            end
        end
    end

    task automatic check(input string name, input longint got, input longint want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic do_reset();
        @(posedge ACLK); #1;
        enable = 1'b0;
        ARESET = 1'b1;
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b0;
    endtask

    task automatic set_cfg(input int g, input int w0, input int w1, input int w2,
                           input int w3, input int fl);
        gap_width = CW'(g);
        frame_len = CW'(fl);
        ch_width[0*CW +: CW] = CW'(w0);
        ch_width[1*CW +: CW] = CW'(w1);
        ch_width[2*CW +: CW] = CW'(w2);
        ch_width[3*CW +: CW] = CW'(w3);
    endtask

    task automatic wait_fs(input int limit, output bit found, output int at);
        found = 1'b0;
        at    = cyc;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge ACLK);
            if (frame_start === 1'b1) begin
                found = 1'b1;
                at    = cyc;
            end
        end
    endtask

    // Samples n cycles starting at the current negedge and records ppm_out run lengths.
    task automatic sample_runs(input int n);
        int   cur;
        logic lvl;
        runs.delete();
        lvl = ppm_out;
        cur = 1;
        for (int i = 1; i < n; i++) begin
            @(negedge ACLK);
            if (ppm_out === lvl) begin
                cur++;
            end else begin
                runs.push_back(cur);
                lvl = ppm_out;
                cur = 1;
            end
        end
        runs.push_back(cur);
    endtask

    task automatic check_runs(input string name, input int n, input int exp_r[10]);
        sample_runs(n);
        check($sformatf("%s run count", name), runs.size(), 10);
        for (int i = 0; i < 10 && i < runs.size(); i++) begin
            check($sformatf("%s run%0d", name, i), runs[i], exp_r[i]);
        end
    endtask

    initial begin
        bit found;
        int t0;
        int t1;
        int t2;
        int er[10];

        // Reset state
        set_cfg(2, 3, 4, 5, 6, 40);
        do_reset();
        chk_en = 1'b1;
        @(negedge ACLK);
        check("reset ppm_out", ppm_out, 1);
        check("reset busy", busy, 0);
        check("reset overrun", overrun, 0);

        // Nominal frame, enable held high
        @(posedge ACLK); #1 enable = 1'b1;
        wait_fs(10, found, t0);
        check("nominal first frame_start", found, 1);
        er = '{2, 3, 2, 4, 2, 5, 2, 6, 2, 12};
        check_runs("nominal", 40, er);
        wait_fs(10, found, t1);
        check("nominal frame period", t1 - t0, 40);

        // Frame too short: SYNC shrinks to one cycle, overrun sticks
        set_cfg(2, 3, 4, 5, 6, 20);
        do_reset();
        @(posedge ACLK); #1 enable = 1'b1;
        wait_fs(10, found, t0);
        er = '{2, 3, 2, 4, 2, 5, 2, 6, 2, 1};
        check_runs("overrun", 29, er);
        wait_fs(10, found, t1);
        check("overrun period", t1 - t0, 29);
        check("overrun flag", overrun, 1);
        wait_fs(40, found, t2);
        check("overrun period 2", t2 - t1, 29);
        check("overrun flag held", overrun, 1);

        // Mid-frame width change applies to the next frame only
        set_cfg(2, 3, 4, 5, 6, 40);
        do_reset();
        @(posedge ACLK); #1 enable = 1'b1;
        wait_fs(10, found, t0);
        fork
            begin
                repeat (10) @(negedge ACLK);
                ch_width[1*CW +: CW] = CW'(9);
            end
        join_none
        er = '{2, 3, 2, 4, 2, 5, 2, 6, 2, 12};
        check_runs("shadow current", 40, er);
        wait_fs(10, found, t1);
        er = '{2, 3, 2, 9, 2, 5, 2, 6, 2, 7};
        check_runs("shadow next", 40, er);

        // Enable dropped mid-frame: frame completes, then idle
        set_cfg(2, 3, 4, 5, 6, 40);
        do_reset();
        @(posedge ACLK); #1 enable = 1'b1;
        wait_fs(10, found, t0);
        fork
            begin
                repeat (5) @(negedge ACLK);
                enable = 1'b0;
            end
        join_none
        er = '{2, 3, 2, 4, 2, 5, 2, 6, 2, 12};
        check_runs("disable", 40, er);
        @(negedge ACLK);
        check("disable busy after frame", busy, 0);
        check("disable ppm_out idle", ppm_out, 1);
        wait_fs(60, found, t1);
        check("disable no new frame_start", found, 0);

        // Reset pulse mid-frame
        do_reset();
        @(posedge ACLK); #1 enable = 1'b1;
        wait_fs(10, found, t0);
        repeat (15) @(negedge ACLK);
        ARESET = 1'b1;
        @(negedge ACLK);
        check("mid reset busy", busy, 0);
        check("mid reset ppm_out", ppm_out, 1);
        check("mid reset cur_ch", cur_ch, 0);
        t1 = cyc;
        ARESET = 1'b0;
        wait_fs(10, found, t2);
        check("restart after reset", t2 - t1, 1);

        // Zero widths behave as one clock
        set_cfg(0, 3, 4, 0, 6, 40);
        do_reset();
        @(posedge ACLK); #1 enable = 1'b1;
        wait_fs(10, found, t0);
        er = '{1, 3, 1, 4, 1, 1, 1, 6, 1, 21};
        check_runs("zero widths", 40, er);
        wait_fs(10, found, t1);
        check("zero widths period", t1 - t0, 40);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
